// File: rtl/disp_sync_rx.sv
// Sync-side receiver: recovers pixel/line counts from hsync/vsync, measures timing,
// and locks once LOCK_FRAMES consecutive frames match the nominal timing.
module disp_sync_rx #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 521,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT_END   = 784,
  parameter int unsigned V_ACT_START = 31,
  parameter int unsigned V_ACT_END   = 511,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic        locked,
  output logic        de,
  output logic        sync_err
);

  localparam logic [2:0] StSearch = 3'd0;
  localparam logic [2:0] StCheck  = 3'd1;
  localparam logic [2:0] StLocked = 3'd2;

  localparam logic [10:0] HTot   = 11'(H_TOTAL);
  localparam logic [10:0] VTot   = 11'(V_TOTAL);
  localparam logic [10:0] HSyncW = 11'(H_SYNC);
  localparam logic [9:0]  HActS  = 10'(H_ACT_START);
  localparam logic [9:0]  HActE  = 10'(H_ACT_END);
  localparam logic [9:0]  VActS  = 10'(V_ACT_START);
  localparam logic [9:0]  VActE  = 10'(V_ACT_END);
  localparam logic [3:0]  LockN  = 4'(LOCK_FRAMES);

  // Bit 0/1 synchronize, bit 2 is the history flop for edge detection.
  logic [2:0]  hs_sync_q, hs_sync_d, vs_sync_q, vs_sync_d;
  logic [9:0]  hcount_q, hcount_d, vcount_q, vcount_d;
  logic [10:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic [10:0] hs_cnt_q, hs_cnt_d, hs_width_q, hs_width_d;
  logic [2:0]  state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        frame_bad_q, frame_bad_d;
  logic        seen_q, seen_d;
  logic        sync_err_q, sync_err_d;

  logic        hs_r, hs_f, vs_r;
  logic [10:0] hlen_new, vlen_new;
  logic        h_sat, v_sat, line_bad, frame_ok;

  assign hs_r     = hs_sync_q[1] & ~hs_sync_q[2];
  assign hs_f     = ~hs_sync_q[1] & hs_sync_q[2];
  assign vs_r     = vs_sync_q[1] & ~vs_sync_q[2];
  assign hlen_new = {1'b0, hcount_q} + 11'd1;
  assign vlen_new = {1'b0, vcount_q} + 11'd1;
  // Counters reaching saturation means the corresponding sync has gone missing.
  assign h_sat    = ~hs_r & (hcount_q == 10'h3fe);
  assign v_sat    = ~vs_r & hs_r & (vcount_q == 10'h3fe);
  assign line_bad = (hs_r & seen_q & ((hlen_new != HTot) | (hs_width_q != HSyncW))) | h_sat;
  assign frame_ok = (vlen_new == VTot) & ~frame_bad_q & ~line_bad;

  always_comb begin
    hs_sync_d     = {hs_sync_q[1:0], hsync_in};
    vs_sync_d     = {vs_sync_q[1:0], vsync_in};
    hcount_d      = hcount_q;
    line_len_d    = line_len_q;
    vcount_d      = vcount_q;
    frame_lines_d = frame_lines_q;

    if (hs_r) begin
      line_len_d = hlen_new;
      hcount_d   = '0;
    end else if (hcount_q != 10'h3ff) begin
      hcount_d = hcount_q + 10'd1;
    end

    if (vs_r) begin
      frame_lines_d = vlen_new;
      vcount_d      = '0;
    end else if (hs_r && (vcount_q != 10'h3ff)) begin
      vcount_d = vcount_q + 10'd1;
    end

    if (hs_r) begin
      hs_cnt_d = 11'd1;
    end else if (hs_sync_q[1] && (hs_cnt_q != 11'h7ff)) begin
      hs_cnt_d = hs_cnt_q + 11'd1;
    end else begin
      hs_cnt_d = hs_cnt_q;
    end
    hs_width_d = hs_f ? hs_cnt_q : hs_width_q;
  end

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    frame_bad_d = frame_bad_q;
    sync_err_d  = 1'b0;
    seen_d      = seen_q | hs_r;
    case (state_q)
      StSearch: begin
        if (vs_r) begin
          state_d     = StCheck;
          good_cnt_d  = '0;
          frame_bad_d = 1'b0;
          // An hsync coincident with the entering vsync starts the first measured line.
          seen_d      = hs_r;
        end
      end
      StCheck: begin
        if (vs_r) begin
          frame_bad_d = 1'b0;
          if (!frame_ok) begin
            good_cnt_d = '0;
          end else if ((good_cnt_q + 4'd1) >= LockN) begin
            good_cnt_d = LockN;
            state_d    = StLocked;
          end else begin
            good_cnt_d = good_cnt_q + 4'd1;
          end
        end else if (line_bad) begin
          frame_bad_d = 1'b1;
        end
      end
      StLocked: begin
        if (line_bad || v_sat || (vs_r && (vlen_new != VTot))) begin
          state_d    = StSearch;
          sync_err_d = 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      hs_sync_q     <= '0;
      vs_sync_q     <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      hs_cnt_q      <= '0;
      hs_width_q    <= '0;
      state_q       <= StSearch;
      good_cnt_q    <= '0;
      frame_bad_q   <= 1'b0;
      seen_q        <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      hs_sync_q     <= hs_sync_d;
      vs_sync_q     <= vs_sync_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      hs_cnt_q      <= hs_cnt_d;
      hs_width_q    <= hs_width_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      frame_bad_q   <= frame_bad_d;
      seen_q        <= seen_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign locked      = (state_q == StLocked);
  assign sync_err    = sync_err_q;
  assign de          = locked & (hcount_q >= HActS) & (hcount_q < HActE) &
                       (vcount_q >= VActS) & (vcount_q < VActE);

endmodule

// File: tb/tb_disp_sync_rx.sv
// Bench for disp_sync_rx: scaled-down timing, randomized sync streams, edge-indexed
// reference model of the recovered counts and lock behaviour.
`timescale 1ns/1ps
module tb_disp_sync_rx;
  localparam int HT = 40, VT = 20, HS = 6, HAS = 10, HAE = 34, VAS = 3, VAE = 17, LF = 2;
  localparam int MAXE = 32768;

  logic        clk = 1'b0, rst_n = 1'b1, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [9:0]  hcount, vcount;
  logic [10:0] line_len, frame_lines;
  logic        locked, de, sync_err;
  int          checks = 0, errors = 0;

  always #20 clk = ~clk;

  disp_sync_rx #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT_END(HAE),
    .V_ACT_START(VAS), .V_ACT_END(VAE), .LOCK_FRAMES(LF)
  ) dut (
    .clk_25MHz(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hcount(hcount), .vcount(vcount), .line_len(line_len), .frame_lines(frame_lines),
    .locked(locked), .de(de), .sync_err(sync_err)
  );

  // Reference model: inputs sampled at edge i are kept in sh/sv; a rise sampled at
  // edge k takes effect at edge k+2.
  bit sh [MAXE];
  bit sv [MAXE];
  int n, m_hc, m_vc, m_len, m_fl, m_width, m_mode, m_good;
  bit m_fbad, m_seen, m_err;
  // Stream generator state.
  int g_c, g_l, g_lines = VT, g_short = -1, g_vsw = 2;

  function automatic bit smp(input bit is_v, input int i);
    if (i < 1) return 1'b0;
    return is_v ? sv[i] : sh[i];
  endfunction

  function automatic bit m_locked();
    return m_mode == 2;
  endfunction

  function automatic bit m_de();
    return (m_mode == 2) && m_hc >= HAS && m_hc < HAE && m_vc >= VAS && m_vc < VAE;
  endfunction

  task automatic model_reset();
    n = 0; m_hc = 0; m_vc = 0; m_len = 0; m_fl = 0; m_width = 0; m_mode = 0; m_good = 0;
    m_fbad = 0; m_seen = 0; m_err = 0;
  endtask

  task automatic gen(output logic h, output logic v);
    h = (g_c < HS);
    v = (g_l < g_vsw);
    g_c++;
    if (g_c >= ((g_l == g_short) ? HT - 1 : HT)) begin
      g_c = 0;
      if (g_l == g_short) g_short = -1;
      g_l++;
      if (g_l >= g_lines) begin
        g_l = 0;
        g_vsw = $urandom_range(1, 3);
      end
    end
  endtask

  task automatic tick(input logic h, input logic v);
    int  old_hc, old_vc, w, len_new, fl_new;
    bit  he, ve, hf, bad, vsat, ok;
    hsync_in = h;
    vsync_in = v;
    @(posedge clk);
    n++;
    if (n >= MAXE) begin
      $display("FAIL edge_budget got %0d want < %0d", n, MAXE);
      $fatal(1, "edge budget exceeded");
    end
    sh[n] = h;
    sv[n] = v;
    he = smp(0, n - 2) && !smp(0, n - 3);
    ve = smp(1, n - 2) && !smp(1, n - 3);
    hf = smp(0, n - 3) && !smp(0, n - 2);
    old_hc = m_hc;
    old_vc = m_vc;
    len_new = old_hc + 1;
    fl_new = old_vc + 1;
    bad = he && m_seen && (len_new != HT || m_width != HS);
    if (hf) begin
      w = 0;
      for (int i = n - 3; i >= 1 && sh[i]; i--) w++;
      m_width = (w > 2047) ? 2047 : w;
    end
    if (he) begin
      m_len = len_new;
      m_hc = 0;
    end else begin
      m_hc = (old_hc < 1023) ? old_hc + 1 : 1023;
      if (m_hc == 1023 && old_hc != 1023) bad = 1;
    end
    vsat = 0;
    if (ve) begin
      m_fl = fl_new;
      m_vc = 0;
    end else if (he) begin
      m_vc = (old_vc < 1023) ? old_vc + 1 : 1023;
      vsat = (m_vc == 1023 && old_vc != 1023);
    end
    m_err = 0;
    ok = (fl_new == VT) && !m_fbad && !bad;
    case (m_mode)
      0: begin
        if (ve) begin
          m_mode = 1; m_good = 0; m_fbad = 0; m_seen = he;
        end else if (he) m_seen = 1;
      end
      1: begin
        if (ve) begin
          m_fbad = 0;
          m_good = ok ? m_good + 1 : 0;
          if (m_good >= LF) m_mode = 2;
        end else if (bad) m_fbad = 1;
        if (he) m_seen = 1;
      end
      default: begin
        if (bad || vsat || (ve && fl_new != VT)) begin
          m_mode = 0; m_err = 1;
        end
        if (he) m_seen = 1;
      end
    endcase
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    g_c = 0; g_l = 0; g_lines = VT; g_short = -1; g_vsw = 2;
  endtask

  task automatic test_reset();
    #5 rst_n = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    #1;
    checks++;
    if ({hcount, vcount, line_len, frame_lines} !== 42'd0) begin
      errors++;
      $display("FAIL reset_counts got %h want 0", {hcount, vcount, line_len, frame_lines});
    end
    checks++;
    if ({locked, de, sync_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {locked, de, sync_err});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({hcount, vcount, locked, de, sync_err} !== 23'd0) begin
      errors++;
      $display("FAIL reset_held got %h want 0", {hcount, vcount, locked, de, sync_err});
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_noise();
    logic h = 1'b0, v = 1'b0;
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 7) == 0) h = ~h;
      if ($urandom_range(0, 31) == 0) v = ~v;
      tick(h, v);
      checks++;
      if (hcount !== 10'(m_hc)) begin
        errors++; $display("FAIL noise_hcount got %0d want %0d", hcount, m_hc);
      end
      checks++;
      if (vcount !== 10'(m_vc)) begin
        errors++; $display("FAIL noise_vcount got %0d want %0d", vcount, m_vc);
      end
      checks++;
      if (line_len !== 11'(m_len) || frame_lines !== 11'(m_fl)) begin
        errors++;
        $display("FAIL noise_len got %0d/%0d want %0d/%0d", line_len, frame_lines, m_len, m_fl);
      end
      checks++;
      if (locked !== m_locked() || sync_err !== m_err) begin
        errors++;
        $display("FAIL noise_lock got %b%b want %b%b", locked, sync_err, m_locked(), m_err);
      end
    end
  endtask

  task automatic test_nominal_lock();
    logic h, v, pv = 1'b0;
    int rises = 0, lock_rise = -1;
    do_reset();
    for (int t = 0; t < 4 * VT * HT + 10; t++) begin
      gen(h, v);
      if (v && !pv) rises++;
      pv = v;
      tick(h, v);
      checks++;
      if (hcount !== 10'(m_hc) || vcount !== 10'(m_vc)) begin
        errors++;
        $display("FAIL nom_count got %0d,%0d want %0d,%0d", hcount, vcount, m_hc, m_vc);
      end
      checks++;
      if (line_len !== 11'(m_len) || frame_lines !== 11'(m_fl)) begin
        errors++;
        $display("FAIL nom_len got %0d/%0d want %0d/%0d", line_len, frame_lines, m_len, m_fl);
      end
      checks++;
      if (locked !== m_locked() || sync_err !== m_err) begin
        errors++;
        $display("FAIL nom_lock got %b%b want %b%b", locked, sync_err, m_locked(), m_err);
      end
      if (locked === 1'b1 && lock_rise < 0) lock_rise = rises;
    end
    checks++;
    if (lock_rise != 3) begin
      errors++; $display("FAIL nom_lock_rise got %0d want 3", lock_rise);
    end
    checks++;
    if (line_len !== 11'(HT) || frame_lines !== 11'(VT)) begin
      errors++;
      $display("FAIL nom_final_len got %0d/%0d want %0d/%0d", line_len, frame_lines, HT, VT);
    end
  endtask

  task automatic test_de_window();
    logic h, v;
    int de_cnt = 0;
    for (int t = 0; t < VT * HT; t++) begin
      gen(h, v);
      tick(h, v);
      if (de === 1'b1) de_cnt++;
      checks++;
      if (de !== m_de()) begin
        errors++;
        $display("FAIL de_cycle h=%0d v=%0d got %b want %b", m_hc, m_vc, de, m_de());
      end
    end
    checks++;
    if (de_cnt != (HAE - HAS) * (VAE - VAS)) begin
      errors++; $display("FAIL de_count got %0d want %0d", de_cnt, (HAE - HAS) * (VAE - VAS));
    end
  endtask

  task automatic test_short_line();
    logic h, v, pv = 1'b0;
    int errs = 0, rises = 0, relock_rise = -1;
    g_short = $urandom_range(2, VT - 2);
    for (int t = 0; t < 6 * VT * HT; t++) begin
      gen(h, v);
      if (v && !pv && errs > 0) rises++;
      pv = v;
      tick(h, v);
      if (sync_err === 1'b1) begin
        errs++;
        checks++;
        if (locked !== 1'b0) begin
          errors++; $display("FAIL short_unlock got %b want 0", locked);
        end
      end
      if (errs > 0 && locked === 1'b1 && relock_rise < 0) relock_rise = rises;
      checks++;
      if (locked !== m_locked() || sync_err !== m_err || hcount !== 10'(m_hc)) begin
        errors++;
        $display("FAIL short_cycle got %b%b %0d want %b%b %0d",
                 locked, sync_err, hcount, m_locked(), m_err, m_hc);
      end
    end
    checks++;
    if (errs != 1) begin
      errors++; $display("FAIL short_err_pulses got %0d want 1", errs);
    end
    checks++;
    if (relock_rise != 3) begin
      errors++; $display("FAIL short_relock_rise got %0d want 3", relock_rise);
    end
  endtask

  task automatic test_missing_hsync();
    logic h, v;
    int errs = 0, hc_at_err = -1;
    for (int t = 0; t < HT && g_c != 0; t++) begin
      gen(h, v);
      tick(h, v);
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL miss_pre_locked got %b want 1", locked);
    end
    for (int t = 0; t < 1100; t++) begin
      tick(1'b0, 1'b0);
      if (sync_err === 1'b1) begin
        errs++;
        hc_at_err = hcount;
      end
      checks++;
      if (hcount !== 10'(m_hc) || sync_err !== m_err) begin
        errors++;
        $display("FAIL miss_cycle got %0d %b want %0d %b", hcount, sync_err, m_hc, m_err);
      end
    end
    checks++;
    if (errs != 1 || hc_at_err != 1023) begin
      errors++; $display("FAIL miss_err got %0d@%0d want 1@1023", errs, hc_at_err);
    end
    checks++;
    if (locked !== 1'b0 || hcount !== 10'd1023) begin
      errors++; $display("FAIL miss_final got %b %0d want 0 1023", locked, hcount);
    end
  endtask

  task automatic test_wrong_height();
    logic h, v;
    do_reset();
    g_lines = VT - 1;
    for (int t = 0; t < 5 * (VT - 1) * HT + 10; t++) begin
      gen(h, v);
      tick(h, v);
      checks++;
      if (locked !== 1'b0) begin
        errors++; $display("FAIL height_locked got %b want 0", locked);
      end
      checks++;
      if (frame_lines !== 11'(m_fl)) begin
        errors++; $display("FAIL height_lines got %0d want %0d", frame_lines, m_fl);
      end
    end
    checks++;
    if (frame_lines !== 11'(VT - 1)) begin
      errors++; $display("FAIL height_final got %0d want %0d", frame_lines, VT - 1);
    end
  endtask

  task automatic test_reset_mid();
    logic h, v, pv = 1'b0;
    bit found = 0;
    int rises = 0, lock_rise = -1;
    do_reset();
    for (int t = 0; t < 2 * VT * HT + 10; t++) begin
      gen(h, v);
      tick(h, v);
    end
    for (int t = 0; t < 2 * VT * HT && !found; t++) begin
      gen(h, v);
      tick(h, v);
      if (m_hc == HT / 2 && m_vc == VT / 2) found = 1;
    end
    checks++;
    if (!found || locked !== 1'b1 || hcount !== 10'(HT / 2) || vcount !== 10'(VT / 2)) begin
      errors++;
      $display("FAIL rstmid_pre got %b %b %0d %0d want 1 1 %0d %0d",
               found, locked, hcount, vcount, HT / 2, VT / 2);
    end
    #5 rst_n = 1'b0;
    #1;
    checks++;
    if ({hcount, vcount, line_len, frame_lines, locked, de, sync_err} !== 45'd0) begin
      errors++;
      $display("FAIL rstmid_zero got %h want 0",
               {hcount, vcount, line_len, frame_lines, locked, de, sync_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    g_c = 0; g_l = 0; g_lines = VT; g_short = -1;
    for (int t = 0; t < 3 * VT * HT; t++) begin
      gen(h, v);
      if (v && !pv) rises++;
      pv = v;
      tick(h, v);
      if (locked === 1'b1 && lock_rise < 0) lock_rise = rises;
      checks++;
      if (locked !== m_locked() || de !== m_de() || vcount !== 10'(m_vc)) begin
        errors++;
        $display("FAIL rstmid_cycle got %b%b %0d want %b%b %0d",
                 locked, de, vcount, m_locked(), m_de(), m_vc);
      end
    end
    checks++;
    if (lock_rise != 3) begin
      errors++; $display("FAIL rstmid_relock_rise got %0d want 3", lock_rise);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_noise();
    test_nominal_lock();
    test_de_window();
    test_short_line();
    test_missing_hsync();
    test_wrong_height();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
